// File: rtl/code_tx_pkg.sv
// Shared types for the code sequence transmitter.
//   tx_state_t : transmitter FSM states (IDLE, SEND, DONE)
//   symbol_t   : one 2-bit symbol, {x1,x0}
//   IDLE_SYM   : value driven on x1/x0 when no symbol is being sent
package code_tx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } tx_state_t;

   typedef logic [1:0] symbol_t;

   localparam symbol_t IDLE_SYM = 2'b00;

endpackage

// File: rtl/code_symbol_mem.sv
// DEPTH x 2-bit symbol register file.
//   clk, reset : clock, asynchronous active-high clear of every entry
//   we         : write strobe (already qualified by the caller)
//   wr_addr    : write address; addresses >= DEPTH are ignored
//   wr_data    : symbol to store
//   rd_addr    : read address
//   rd_data    : combinational read of mem[rd_addr]
module code_symbol_mem
   import code_tx_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  symbol_t                  wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output symbol_t                  rd_data
);

   symbol_t mem [DEPTH];

   // NOTE: this is a small flop array, not a RAM macro, so it can take the
   // asynchronous clear; a reset mid-transmission must leave every symbol at 00.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= IDLE_SYM;
      end else if (we && (int'(wr_addr) < DEPTH)) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/code_sequence_tx.sv
// Programmable 2-bit symbol sequence transmitter.
// A host loads up to DEPTH symbols, then pulses start with len/hold; the block
// plays the symbols on x1/x0, each for hold+1 cycles, then pulses done.
//   clk, reset        : clock, asynchronous active-high reset
//   wr_en/addr/data   : symbol memory write port (honoured only in IDLE)
//   len               : symbols to send (1..DEPTH), sampled on accepted start
//   hold              : extra cycles per symbol, sampled on accepted start
//   start, abort      : begin / cancel a transmission
//   x1, x0, sym_valid : current symbol and its qualifier
//   busy, done, err   : in progress, completion pulse, illegal-len pulse
// All outputs are registered.
module code_sequence_tx
   import code_tx_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int HOLD_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [1:0]               wr_data,
   input  logic [$clog2(DEPTH):0]   len,
   input  logic [HOLD_W-1:0]        hold,
   input  logic                     start,
   input  logic                     abort,
   output logic                     x1,
   output logic                     x0,
   output logic                     sym_valid,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   tx_state_t         state;
   logic [AW-1:0]     idx;
   logic [HOLD_W-1:0] cnt;
   logic [LW-1:0]     len_q;
   logic [HOLD_W-1:0] hold_q;

   logic              len_ok;
   logic              accept;
   logic              last;
   logic              mem_we;
   logic [AW-1:0]     rd_addr;
   symbol_t           rd_data;

   assign len_ok = (len != '0) && (len <= LW'(DEPTH));
   // abort wins over start in IDLE, so an aborted start is neither accepted nor an error
   assign accept = (state == IDLE) && start && !abort && len_ok;
   // idx is widened so len_q = DEPTH compares without wrapping
   assign last   = (({1'b0, idx} + 1'b1) == len_q);
   assign mem_we = wr_en && (state == IDLE) && !accept;

   // Address the symbol that will be on x1/x0 after the coming edge, so the
   // outputs can be loaded straight into flops.
   // NOTE: rd_addr is given a default before any branch so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rd_addr = idx;
      if (state == IDLE)
         rd_addr = '0;
      else if ((state == SEND) && (cnt == '0) && !last)
         rd_addr = idx + 1'b1;
   end

   code_symbol_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .reset   (reset),
      .we      (mem_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // NOTE: every state and output flop here uses non-blocking assignment so
   // all of them update together from the values seen before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= '0;
         cnt       <= '0;
         len_q     <= '0;
         hold_q    <= '0;
         {x1, x0}  <= IDLE_SYM;
         sym_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= SEND;
                  idx       <= '0;
                  cnt       <= hold;
                  len_q     <= len;
                  hold_q    <= hold;
                  {x1, x0}  <= rd_data;
                  sym_valid <= 1'b1;
                  busy      <= 1'b1;
               end else if (start && !abort) begin
                  err <= 1'b1;
               end
            end
            SEND: begin
               if (abort) begin
                  state     <= IDLE;
                  idx       <= '0;
                  cnt       <= '0;
                  {x1, x0}  <= IDLE_SYM;
                  sym_valid <= 1'b0;
                  busy      <= 1'b0;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!last) begin
                  idx      <= idx + 1'b1;
                  cnt      <= hold_q;
                  {x1, x0} <= rd_data;
               end else begin
                  state     <= DONE;
                  {x1, x0}  <= IDLE_SYM;
                  sym_valid <= 1'b0;
                  done      <= 1'b1;
               end
            end
            DONE: begin
               // Abort here lands in the same place as normal completion.
               state <= IDLE;
               idx   <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               {x1, x0}  <= IDLE_SYM;
               sym_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_code_sequence_tx.sv
// Directed self-checking bench for code_sequence_tx (DEPTH=8, HOLD_W=4).
module tb_code_sequence_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [1:0] wr_data;
   logic [3:0] len;
   logic [3:0] hold;
   logic       start;
   logic       abort;
   logic       x1, x0, sym_valid, busy, done, err;

   // Observed outputs packed as {busy, sym_valid, done, err, x1, x0}
   logic [5:0] o;
   assign o = {busy, sym_valid, done, err, x1, x0};

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [1:0] code [5] = '{2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
   logic [1:0] big  [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};

   code_sequence_tx #(.DEPTH(8), .HOLD_W(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .len       (len),
      .hold      (hold),
      .start     (start),
      .abort     (abort),
      .x1        (x1),
      .x0        (x0),
      .sym_valid (sym_valid),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input logic [2:0] a, input logic [1:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic load_code();
      for (int i = 0; i < 5; i++) write_mem(3'(i), code[i]);
   endtask

   // Drive start for one edge; afterwards the bench sits in the first SEND cycle.
   task automatic fire(input logic [3:0] l, input logic [3:0] h);
      len = l; hold = h; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [5:0] exp;
      exp = 6'b0;
      #3;
      total_cnt++;
      if (o !== exp) $display("FAIL reset_async obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      total_cnt++;
      if (o !== exp) $display("FAIL reset_held obs=%b exp=%b", o, exp); else pass_cnt++;
      reset = 1'b0;
      tick();
      total_cnt++;
      if (o !== exp) $display("FAIL reset_release obs=%b exp=%b", o, exp); else pass_cnt++;
   endtask

   task automatic test_unlock();
      logic [5:0] exp;
      load_code();
      fire(4'd5, 4'd0);
      for (int i = 0; i < 5; i++) begin
         exp = {4'b1100, code[i]};
         total_cnt++;
         if (o !== exp) $display("FAIL unlock_sym%0d obs=%b exp=%b", i, o, exp); else pass_cnt++;
         tick();
      end
      exp = 6'b101000;
      total_cnt++;
      if (o !== exp) $display("FAIL unlock_done obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      exp = 6'b0;
      total_cnt++;
      if (o !== exp) $display("FAIL unlock_idle obs=%b exp=%b", o, exp); else pass_cnt++;
   endtask

   task automatic test_hold();
      logic [5:0] exp;
      fire(4'd5, 4'd2);
      for (int c = 0; c < 15; c++) begin
         exp = {4'b1100, code[c / 3]};
         total_cnt++;
         if (o !== exp) $display("FAIL hold_cycle%0d obs=%b exp=%b", c, o, exp); else pass_cnt++;
         tick();
      end
      exp = 6'b101000;
      total_cnt++;
      if (o !== exp) $display("FAIL hold_done obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      exp = 6'b0;
      total_cnt++;
      if (o !== exp) $display("FAIL hold_idle obs=%b exp=%b", o, exp); else pass_cnt++;
   endtask

   task automatic test_illegal_len();
      logic [5:0] exp;
      logic [3:0] bad [2] = '{4'd0, 4'd9};
      for (int k = 0; k < 2; k++) begin
         fire(bad[k], 4'd0);
         exp = 6'b000100;
         total_cnt++;
         if (o !== exp) $display("FAIL illegal_err len=%0d obs=%b exp=%b", bad[k], o, exp); else pass_cnt++;
         tick();
         exp = 6'b0;
         total_cnt++;
         if (o !== exp) $display("FAIL illegal_clear len=%0d obs=%b exp=%b", bad[k], o, exp); else pass_cnt++;
      end
      // abort together with start in IDLE: start ignored, no error
      abort = 1'b1;
      fire(4'd5, 4'd0);
      abort = 1'b0;
      exp = 6'b0;
      total_cnt++;
      if (o !== exp) $display("FAIL abort_start_idle obs=%b exp=%b", o, exp); else pass_cnt++;
   endtask

   task automatic test_abort();
      logic [5:0] exp;
      fire(4'd5, 4'd0);
      tick();
      tick();
      exp = {4'b1100, code[2]};
      total_cnt++;
      if (o !== exp) $display("FAIL abort_sym2 obs=%b exp=%b", o, exp); else pass_cnt++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp = 6'b0;
      total_cnt++;
      if (o !== exp) $display("FAIL abort_idle obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      total_cnt++;
      if (o !== exp) $display("FAIL abort_no_done obs=%b exp=%b", o, exp); else pass_cnt++;
      fire(4'd5, 4'd0);
      for (int i = 0; i < 5; i++) begin
         exp = {4'b1100, code[i]};
         total_cnt++;
         if (o !== exp) $display("FAIL abort_restart_sym%0d obs=%b exp=%b", i, o, exp); else pass_cnt++;
         tick();
      end
      exp = 6'b101000;
      total_cnt++;
      if (o !== exp) $display("FAIL abort_restart_done obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_protect();
      logic [5:0] exp;
      fire(4'd5, 4'd0);
      // write 00 to address 0 and re-request start while busy
      wr_en = 1'b1; wr_addr = 3'd0; wr_data = 2'b00; start = 1'b1; len = 4'd2; hold = 4'd3;
      tick();
      wr_en = 1'b0; start = 1'b0;
      for (int i = 1; i < 5; i++) begin
         exp = {4'b1100, code[i]};
         total_cnt++;
         if (o !== exp) $display("FAIL protect_sym%0d obs=%b exp=%b", i, o, exp); else pass_cnt++;
         tick();
      end
      exp = 6'b101000;
      total_cnt++;
      if (o !== exp) $display("FAIL protect_done obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      fire(4'd1, 4'd0);
      exp = {4'b1100, 2'b11};
      total_cnt++;
      if (o !== exp) $display("FAIL protect_mem0 obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      tick();
   endtask

   task automatic test_max();
      logic [5:0] exp;
      int         bad_cycles;
      for (int i = 0; i < 8; i++) write_mem(3'(i), big[i]);
      fire(4'd8, 4'd15);
      bad_cycles = 0;
      for (int c = 0; c < 128; c++) begin
         exp = {4'b1100, big[c / 16]};
         if (o !== exp) begin
            if (bad_cycles == 0) $display("FAIL max_cycle%0d obs=%b exp=%b", c, o, exp);
            bad_cycles++;
         end
         tick();
      end
      total_cnt++;
      if (bad_cycles != 0) $display("FAIL max_sequence bad_cycles=%0d exp=0", bad_cycles); else pass_cnt++;
      exp = 6'b101000;
      total_cnt++;
      if (o !== exp) $display("FAIL max_done obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid_send();
      logic [5:0] exp;
      fire(4'd8, 4'd2);
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      exp = 6'b0;
      total_cnt++;
      if (o !== exp) $display("FAIL midreset_async obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      reset = 1'b0;
      tick();
      total_cnt++;
      if (o !== exp) $display("FAIL midreset_release obs=%b exp=%b", o, exp); else pass_cnt++;
      fire(4'd1, 4'd0);
      exp = 6'b110000;
      total_cnt++;
      if (o !== exp) $display("FAIL midreset_sym00 obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      exp = 6'b101000;
      total_cnt++;
      if (o !== exp) $display("FAIL midreset_done obs=%b exp=%b", o, exp); else pass_cnt++;
      tick();
      exp = 6'b0;
      total_cnt++;
      if (o !== exp) $display("FAIL midreset_idle obs=%b exp=%b", o, exp); else pass_cnt++;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      len = '0; hold = '0; start = 1'b0; abort = 1'b0;
      test_reset();
      test_unlock();
      test_hold();
      test_illegal_len();
      test_abort();
      test_protect();
      test_max();
      test_reset_mid_send();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/code_sequence_tx.md
# code_sequence_tx

Programmable 2-bit symbol sequence transmitter: the source end of the two-wire `x1`/`x0` symbol interface consumed by the team's sequence-detector (lock) FSMs. A host loads up to `DEPTH` symbols and a length, then pulses `start`. The block drives the symbols one after another, each held for a programmable number of cycles, and signals completion. It sits in the test/stimulus path and in the system top, feeding the detector's `X1`/`X0` inputs on the same `clk`.

## Interface
- `DEPTH`, default 8: symbol memory depth. Must be 2 or greater.
- `HOLD_W`, default 4: width of the per-symbol hold count.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write strobe for the symbol memory.
- `wr_addr`  in  $clog2(DEPTH)  write address.
- `wr_data`  in  2  symbol to write, `{x1,x0}`.
- `len`  in  $clog2(DEPTH)+1  number of symbols to send; sampled when `start` is accepted.
- `hold`  in  HOLD_W  extra cycles per symbol; each symbol lasts `hold`+1 cycles. Sampled when `start` is accepted.
- `start`  in  1  request to send; level-sampled.
- `abort`  in  1  cancels a transmission in progress.
- `x1`, `x0`  out  1 each  symbol bits; idle value 00.
- `sym_valid`  out  1  high while a loaded symbol is on `x1`/`x0`.
- `busy`  out  1  transmission in progress (SEND or DONE).
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse: `start` was rejected because of an illegal `len`.

## Operation
- States: IDLE, SEND, DONE.
- IDLE:
  - `x1`/`x0`=00; `sym_valid`, `busy`, `done` are 0.
  - `start` with 1≤`len`≤`DEPTH` → latch `len`/`hold`, idx=0, cnt=`hold` → SEND.
  - `start` with `len`=0 or `len`>`DEPTH` → `err`=1 for one cycle; stay in IDLE.
- SEND:
  - Outputs are `mem[idx]`; `sym_valid`=1, `busy`=1.
  - cnt>0 → cnt−1.
  - cnt=0 and idx<len−1 → idx+1, cnt=hold.
  - cnt=0 and idx=len−1 → DONE.
- DONE: exactly one cycle. `done`=1, `busy`=1, `sym_valid`=0, `x1`/`x0`=00. Then → IDLE.
- `start` while `busy`=1 is ignored; no error.
- `abort` in SEND or DONE → IDLE at the next edge. Outputs go to the IDLE values; `done` is not pulsed. `abort` in IDLE has no effect.
- `abort` and `start` in the same IDLE cycle: `abort` wins and `start` is ignored.
- `wr_en` is honoured only in IDLE cycles where `start` is not accepted. It is silently dropped while `busy`=1 or in the cycle `start` is accepted.
- `wr_addr`≥`DEPTH`: the write is dropped.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset (asynchronous, any state, including mid-SEND): state=IDLE, all memory entries=00, idx=0, cnt=0. All outputs are 0 while `reset` is high and after release.
- `start` accepted at edge k: first symbol is valid from edge k until edge k+hold+1.
- Symbol i occupies cycles k+i·(hold+1) … k+(i+1)·(hold+1)−1.
- DONE is the cycle starting at edge k+len·(hold+1). `busy` lasts len·(hold+1)+1 cycles.
- Earliest next `start` is accepted in the first IDLE cycle after DONE, i.e. the edge after `done` is seen high.
- `err` is asserted in the cycle after the rejected `start`.
- `len`=`DEPTH` and `hold`=2^HOLD_W−1 are legal and must not wrap idx or cnt.

## Structure
- Package `code_tx_pkg`:
  - state enum `tx_state_t` (IDLE, SEND, DONE);
  - `symbol_t` = logic [1:0];
  - constant `IDLE_SYM` = 2'b00.
- Sub-module `code_symbol_mem`: `DEPTH`×2-bit register file with asynchronous clear, one write port and one read port.
- The FSM and counters live in `code_sequence_tx`.

## Test plan
- Unlock code, `hold`=0: load [11,10,10,01,01], `len`=5, `start` → `x1x0`=11,10,10,01,01 in 5 consecutive cycles with `sym_valid`=1, then `done` for 1 cycle; `busy` high for 6 cycles.
- Hold: same code, `hold`=2 → each symbol is held for exactly 3 cycles; `done` arrives 15 cycles after the accepting edge.
- Illegal length: `start` with `len`=0 → `err` pulse, `busy` stays 0. Repeat with `len`=9 (`DEPTH`=8) → same response.
- Abort: `abort` during the 3rd symbol → next cycle is IDLE (`x1x0`=00, `busy`=0); no `done`. A following `start` restarts from symbol 0.
- Protection: `wr_en` to address 0 with 00 while `busy`=1, plus a `start` while busy → memory is unchanged and the running sequence is undisturbed. Rerunning shows symbol 0 = 11.
- Reset mid-SEND: assert `reset` asynchronously → outputs 0 immediately. After release, memory reads 00 and `start` with `len`=1 sends 00 with `sym_valid`=1.
